// File: rtl/aes_key_expand_pkg.sv
// Shared definitions for the iterative AES-128 key schedule: FSM encoding,
// round-constant table, word slicing and the GF(2^8) arithmetic used by the S-box.
package aes_key_expand_pkg;

    localparam int AES_NR_128 = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round constant for round index 1..10; other indices never reach the datapath.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // w0 is the most significant word of a 128-bit block, w3 the least.
    function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] idx);
        case (idx)
            2'd0:    return blk[127:96];
            2'd1:    return blk[95:64];
            2'd2:    return blk[63:32];
            default: return blk[31:0];
        endcase
    endfunction

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box cell: multiplicative inverse in GF(2^8) followed by the
// affine transform. Inverse is a^254, which conveniently maps 0 to 0.
module aes_sbox
    import aes_key_expand_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] inv;

    // a^254 by square-and-multiply: accumulate a^2, a^4, ... a^128.
    always_comb begin : inverse
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        y = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/key_round_step.sv
// One AES-128 key-schedule step: given round key i and rcon[i+1],
// produce round key i+1. Purely combinational.
module key_round_step
    import aes_key_expand_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rc,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0  = get_word(rk, 2'd0);
    assign w1  = get_word(rk, 2'd1);
    assign w2  = get_word(rk, 2'd2);
    assign w3  = get_word(rk, 2'd3);
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox3 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sbox2 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sbox1 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sbox0 (.a(rot[7:0]),   .y(sub[7:0]));

    // Each new word chains off the previous new word.
    always_comb begin
        t  = sub ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        rk_next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. Emits round keys 0..NR, one per accepted
// transfer, keeping only the current 128-bit round key in storage.
//
// Handshake: a round key is transferred on a rising edge where rk_valid and
// rk_ready are both high. rk_valid, rk and rk_round stay stable until that
// edge; rk_valid never depends combinationally on rk_ready.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int NR = AES_NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state;
    state_t       state_next;
    logic         xfer;
    logic         last_round;
    logic         load_key;
    logic         advance;
    logic         finish;
    logic [7:0]   rc;
    logic [127:0] rk_step;

    assign xfer       = rk_valid & rk_ready;
    assign last_round = (rk_round == LAST_ROUND);
    assign rc         = rcon(rk_round + 4'd1);
    assign busy       = (state == ST_RUN);

    key_round_step u_step (
        .rk      (rk),
        .rc      (rc),
        .rk_next (rk_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on start, return after the last key is taken.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)             state_next = ST_RUN;
            ST_RUN:  if (xfer && last_round) state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Output decode: which datapath update happens at the next edge.
    always_comb begin
        load_key = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: load_key = start;
            ST_RUN: begin
                advance = xfer & ~last_round;
                finish  = xfer &  last_round;
            end
            default: ;
        endcase
    end

    // Registered outputs; rk and rk_round keep their last values after finish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_valid <= 1'b0;
            rk_round <= 4'd0;
            rk       <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load_key) begin
                rk       <= key_in;
                rk_round <= 4'd0;
                rk_valid <= 1'b1;
            end else if (advance) begin
                rk       <= rk_step;
                rk_round <= rk_round + 4'd1;
            end else if (finish) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key vectors,
// backpressure, ignored start, mid-run reset and start-on-done.
module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] exp_q[$];
    logic [127:0] fips_rk[0:10];

    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[0:7];

    aes_key_expand #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk       (rk),
        .busy     (busy),
        .done     (done)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_fips_queue();
        exp_q.delete();
        for (int i = 0; i <= 10; i++) exp_q.push_back(fips_rk[i]);
    endtask

    // Start an expansion and capture the key carried at a given round.
    task automatic capture(input logic [127:0] key, input logic [3:0] round,
                           output logic [127:0] got, output bit ok);
        int budget;
        ok  = 1'b0;
        got = '0;
        @(negedge clk);
        start = 1'b1; key_in = key; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (busy && budget < 40) begin
            if (rk_valid && rk_round == round && !ok) begin
                got = rk;
                ok  = 1'b1;
            end
            budget++;
            @(negedge clk);
        end
        check("capture_finished", {127'b0, busy}, 128'd0);
        @(negedge clk);
    endtask

    // Full expansion against exp_q, with optional stall, injected start and
    // chained start on the done cycle.
    task automatic expand(input logic [127:0] key, input int stall_round, input int stall_len,
                          input int inject_round, input bit chain, input logic [127:0] chain_key);
        int stall_cnt    = 0;
        int valid_cycles = 0;
        int budget       = 0;
        int exp_round    = 0;
        logic [127:0] last_rk;
        last_rk = '0;
        @(negedge clk);
        start = 1'b1; key_in = key; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key_in = ~key;
        while (exp_q.size() > 0 && budget < 100) begin
            budget++;
            start = 1'b0;
            check("rk_valid_run", {127'b0, rk_valid}, 128'd1);
            check("busy_run", {127'b0, busy}, 128'd1);
            check("done_run", {127'b0, done}, 128'd0);
            check("rk_round", {124'b0, rk_round}, 128'(exp_round));
            check("rk", rk, exp_q[0]);
            if (rk_valid) valid_cycles++;
            if (exp_round == stall_round && stall_cnt < stall_len) begin
                stall_cnt++;
                rk_ready = 1'b0;
            end else begin
                rk_ready = 1'b1;
                last_rk  = exp_q.pop_front();
                if (exp_round == inject_round) begin
                    start  = 1'b1;
                    key_in = ALT_KEY;
                end
                exp_round++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL expand_timeout: got %0d keys left expected 0", exp_q.size());
            exp_q.delete();
        end
        check("done_pulse", {127'b0, done}, 128'd1);
        check("rk_valid_end", {127'b0, rk_valid}, 128'd0);
        check("busy_end", {127'b0, busy}, 128'd0);
        check("rk_round_end", {124'b0, rk_round}, 128'd10);
        check("rk_end", rk, last_rk);
        check("valid_cycles", 128'(valid_cycles), 128'(11 + stall_len));
        if (chain) begin
            start = 1'b1; key_in = chain_key;
            @(negedge clk);
            start = 1'b0;
            check("chain_valid", {127'b0, rk_valid}, 128'd1);
            check("chain_round", {124'b0, rk_round}, 128'd0);
            check("chain_rk", rk, chain_key);
            check("chain_busy", {127'b0, busy}, 128'd1);
            check("chain_done", {127'b0, done}, 128'd0);
            budget = 0;
            rk_ready = 1'b1;
            while (busy && budget < 40) begin
                budget++;
                @(negedge clk);
            end
            check("chain_drain_done", {127'b0, done}, 128'd1);
        end
        @(negedge clk);
        check("done_clear", {127'b0, done}, 128'd0);
    endtask

    initial begin
        logic [127:0] got;
        bit           ok;
        int           budget;

        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{FIPS_KEY, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{FIPS_KEY, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{ZERO_KEY, 4'd0,  128'h00000000000000000000000000000000};
        vecs[5] = '{ZERO_KEY, 4'd1,  128'h62636363626363636263636362636363};
        vecs[6] = '{ZERO_KEY, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[7] = '{FIPS_KEY, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};

        // Reset.
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {127'b0, rk_valid}, 128'd0);
        check("reset_round", {124'b0, rk_round}, 128'd0);
        check("reset_rk", rk, 128'd0);
        check("reset_busy", {127'b0, busy}, 128'd0);
        check("reset_done", {127'b0, done}, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_valid", {127'b0, rk_valid}, 128'd0);
        check("idle_busy", {127'b0, busy}, 128'd0);

        // Table-driven round-key vectors.
        for (int i = 0; i < 8; i++) begin
            capture(vecs[i].key, vecs[i].round, got, ok);
            check($sformatf("vec%0d_found", i), {127'b0, ok}, 128'd1);
            check($sformatf("vec%0d_rk", i), got, vecs[i].exp);
        end

        // Full unstalled FIPS run.
        load_fips_queue();
        expand(FIPS_KEY, -1, 0, -1, 1'b0, '0);

        // Backpressure at round 4 for three cycles.
        load_fips_queue();
        expand(FIPS_KEY, 4, 3, -1, 1'b0, '0);

        // Start with a different key at round 3 is ignored.
        load_fips_queue();
        expand(FIPS_KEY, -1, 0, 3, 1'b0, '0);

        // Reset at round 6 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!(rk_valid && rk_round == 4'd6) && budget < 40) begin
            budget++;
            @(negedge clk);
        end
        check("reach_round6", {124'b0, rk_round}, 128'd6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", {127'b0, rk_valid}, 128'd0);
        check("abort_round", {124'b0, rk_round}, 128'd0);
        check("abort_rk", rk, 128'd0);
        check("abort_busy", {127'b0, busy}, 128'd0);
        check("abort_done", {127'b0, done}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {127'b0, done}, 128'd0);
            check("abort_no_valid", {127'b0, rk_valid}, 128'd0);
        end
        load_fips_queue();
        expand(FIPS_KEY, -1, 0, -1, 1'b0, '0);

        // Start in the done cycle.
        load_fips_queue();
        expand(FIPS_KEY, -1, 0, -1, 1'b1, ALT_KEY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
